// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: assembles framed little-endian words and holds the core in reset until loaded.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [9:0] START_PC = 10'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [9:0]  PC_write,
  output logic [31:0] instruction_in,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd6;
`endif

  logic [2:0]      state_q, state_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [3*BW-1:0] word_buf_q, word_buf_d;
  logic            rx_ready_q, rx_ready_d;
  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   instr_q, instr_d;
  logic            core_reset_q, core_reset_d;
  logic            load_done_q, load_done_d;
  logic            load_error_q, load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BW-1:0]   sum_q, sum_d;
`endif

  logic            accept;
  logic            can_start;
  logic [2:0]      st_after_data;
  logic [AW-1:0]   len_full;

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imem_we_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
    st_after_data = ST_CSUM;
    can_start     = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
`else
    st_after_data = ST_DONE;
    can_start     = (state_q == ST_IDLE) || (state_q == ST_DONE);
`endif
    accept   = rx_valid && rx_ready_q;
    len_full = {rx_data[1:0], len_q[7:0]};

    // Address and word count advance in the cycle after each strobe
    if (imem_we_q) begin
      pc_d       = AW'(pc_q + 10'd1);
      word_cnt_d = AW'(word_cnt_q + 10'd1);
    end

    case (state_q)
      ST_LEN_LO: begin
        if (accept) begin
          len_d   = {2'b00, rx_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = len_full;
          state_d = (len_full == '0) ? st_after_data : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          byte_idx_d = 2'(byte_idx_q + 2'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = 8'(sum_q + rx_data);
`endif
          case (byte_idx_q)
            2'd0:    word_buf_d[7:0]   = rx_data;
            2'd1:    word_buf_d[15:8]  = rx_data;
            2'd2:    word_buf_d[23:16] = rx_data;
            default: begin
              imem_we_d = 1'b1;
              instr_d   = {rx_data, word_buf_q};
            end
          endcase
        end
        if (imem_we_q && (AW'(word_cnt_q + 10'd1) == len_q)) begin
          state_d = st_after_data;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = (8'(sum_q + rx_data) == 8'h00) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: ;
    endcase

    if (start && can_start) begin
      state_d    = ST_LEN_LO;
      word_cnt_d = '0;
      byte_idx_d = '0;
      pc_d       = START_PC;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d = '0;
`endif
    end

    load_done_d  = (state_d == ST_DONE);
    core_reset_d = (state_d != ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    load_error_d = (state_d == ST_ERR);
    rx_ready_d   = ((state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                    (state_d == ST_DATA) || (state_d == ST_CSUM)) && !imem_we_d;
`else
    load_error_d = 1'b0;
    rx_ready_d   = ((state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                    (state_d == ST_DATA)) && !imem_we_d;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      pc_q         <= START_PC;
      instr_q      <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign rx_ready       = rx_ready_q;
  assign imem_we        = imem_we_q;
  assign PC_write       = pc_q;
  assign instruction_in = instr_q;
  assign core_reset     = core_reset_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (START_PC 0 and 1023) share one byte stream;
// observed writes are compared against a word-list model of the frame.
module tb_imem_loader;

  localparam logic [9:0] PC_A = 10'd0;
  localparam logic [9:0] PC_B = 10'd1023;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        rx_ready_a, imem_we_a, core_reset_a, load_done_a, load_error_a;
  logic [9:0]  pc_a;
  logic [31:0] instr_a;
  logic        rx_ready_b, imem_we_b, core_reset_b, load_done_b, load_error_b;
  logic [9:0]  pc_b;
  logic [31:0] instr_b;

  always #5 clock = ~clock;

  imem_loader #(.START_PC(PC_A)) dut_a (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_a), .imem_we(imem_we_a), .PC_write(pc_a), .instruction_in(instr_a),
    .core_reset(core_reset_a), .load_done(load_done_a), .load_error(load_error_a)
  );

  imem_loader #(.START_PC(PC_B)) dut_b (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_b), .imem_we(imem_we_b), .PC_write(pc_b), .instruction_in(instr_b),
    .core_reset(core_reset_b), .load_done(load_done_b), .load_error(load_error_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int bad_ready = 0;
  logic [41:0] wr_a[$], wr_b[$], exp_a[$], exp_b[$];
  logic [31:0] words_q[$];
  logic [7:0]  frame_q[$];

  // Write-port observer
  always @(negedge clock) begin
    if (imem_we_a) begin
      wr_a.push_back({pc_a, instr_a});
      if (rx_ready_a) bad_ready++;
    end
    if (imem_we_b) begin
      wr_b.push_back({pc_b, instr_b});
      if (rx_ready_b) bad_ready++;
    end
  end

  task automatic build_frame();
    logic [9:0] n;
    logic [7:0] s;
    logic [7:0] b;
    n = 10'(words_q.size());
    s = 8'h00;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back({6'($urandom), n[9:8]});
    foreach (words_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = words_q[i][8*k +: 8];
        frame_q.push_back(b);
        s = 8'(s + b);
      end
    end
    if (CSUM) frame_q.push_back(8'(8'd0 - s));
  endtask

  task automatic model_writes();
    exp_a.delete();
    exp_b.delete();
    foreach (words_q[i]) begin
      exp_a.push_back({10'((int'(PC_A) + i) % 1024), words_q[i]});
      exp_b.push_back({10'((int'(PC_B) + i) % 1024), words_q[i]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    wr_a.delete();
    wr_b.delete();
    bad_ready = 0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drive_bytes(input int count, input int pct);
    int idx = 0;
    int cyc = 0;
    while (idx < count && cyc < 3000) begin
      @(negedge clock);
      rx_valid = ($urandom_range(99) < pct);
      rx_data  = rx_valid ? frame_q[idx] : 8'($urandom);
      if (rx_valid && rx_ready_a) idx++;
      cyc++;
    end
    @(negedge clock);
    rx_valid = 1'b0;
    if (idx < count) begin
      n_tests++;
      n_fail++;
      $display("FAIL drive_timeout sent %0d of %0d bytes", idx, count);
    end
  endtask

  task automatic run_load(input int pct, output int lat);
    pulse_start();
    drive_bytes(frame_q.size(), pct);
    lat = 1;
    while (!(load_done_a || load_error_a) && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_tests++;
    if ({rx_ready_a, imem_we_a, pc_a, instr_a, core_reset_a, load_done_a, load_error_a} !==
        {1'b0, 1'b0, PC_A, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a got rdy=%b we=%b pc=%0d in=%h cr=%b d=%b e=%b", rx_ready_a, imem_we_a,
               pc_a, instr_a, core_reset_a, load_done_a, load_error_a);
    end
    n_tests++;
    if ({rx_ready_b, imem_we_b, pc_b, instr_b, core_reset_b, load_done_b, load_error_b} !==
        {1'b0, 1'b0, PC_B, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b got rdy=%b we=%b pc=%0d in=%h cr=%b d=%b e=%b", rx_ready_b, imem_we_b,
               pc_b, instr_b, core_reset_b, load_done_b, load_error_b);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    words_q = '{32'h00113083, 32'h00A53183, 32'h00118333};
    build_frame();
    model_writes();
    run_load(100, lat);
    n_tests++;
    if (wr_a.size() != 3 || wr_b.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count got a=%0d b=%0d exp 3", wr_a.size(), wr_b.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (wr_a[i] !== exp_a[i] || wr_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL basic_write[%0d] got a=%h b=%h exp a=%h b=%h", i, wr_a[i], wr_b[i], exp_a[i], exp_b[i]);
      end
    end
    n_tests++;
    if ({load_done_a, core_reset_a, load_error_a, load_done_b, core_reset_b} !== 5'b10010) begin
      n_fail++;
      $display("FAIL basic_flags got d=%b cr=%b e=%b d_b=%b cr_b=%b exp 1 0 0 1 0",
               load_done_a, core_reset_a, load_error_a, load_done_b, core_reset_b);
    end
    n_tests++;
    if (lat != (CSUM ? 1 : 2)) begin
      n_fail++;
      $display("FAIL basic_done_latency got %0d exp %0d", lat, CSUM ? 1 : 2);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    words_q = '{$urandom, $urandom};
    build_frame();
    model_writes();
    for (int pass = 0; pass < 2; pass++) begin
      run_load(pass == 0 ? 100 : 45, lat);
      n_tests++;
      if (wr_a.size() != 2) begin
        n_fail++;
        $display("FAIL bp_count pass %0d got %0d exp 2", pass, wr_a.size());
      end
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (wr_a[i] !== exp_a[i] || wr_b[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL bp_write[%0d] pass %0d got a=%h b=%h exp a=%h b=%h", i, pass,
                   wr_a[i], wr_b[i], exp_a[i], exp_b[i]);
        end
      end
      n_tests++;
      if (bad_ready != 0 || load_done_a !== 1'b1 || core_reset_a !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_flags pass %0d got ready_in_strobe=%0d done=%b cr=%b exp 0 1 0",
                 pass, bad_ready, load_done_a, core_reset_a);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      build_frame();
      model_writes();
      run_load($urandom_range(30, 100), lat);
      n_tests++;
      if (wr_a.size() != n || wr_b.size() != n) begin
        n_fail++;
        $display("FAIL rand_count it %0d got a=%0d b=%0d exp %0d", it, wr_a.size(), wr_b.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (wr_a[i] !== exp_a[i] || wr_b[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL rand_write[%0d] it %0d got a=%h b=%h exp a=%h b=%h", i, it,
                   wr_a[i], wr_b[i], exp_a[i], exp_b[i]);
        end
      end
      n_tests++;
      if (bad_ready != 0 || load_done_a !== 1'b1 || core_reset_a !== 1'b0 || load_error_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_flags it %0d got ready_in_strobe=%0d d=%b cr=%b e=%b",
                 it, bad_ready, load_done_a, core_reset_a, load_error_a);
      end
    end
  endtask

  task automatic test_zero_len();
    int lat;
    words_q.delete();
    build_frame();
    run_load(100, lat);
    n_tests++;
    if (wr_a.size() != 0 || wr_b.size() != 0 || load_done_a !== 1'b1 || core_reset_a !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL zero_len got writes=%0d/%0d done=%b cr=%b lat=%0d exp 0/0 1 0 1",
               wr_a.size(), wr_b.size(), load_done_a, core_reset_a, lat);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int lat;
    words_q = '{32'h04030201};
    build_frame();
    frame_q[frame_q.size()-1] = 8'hF7;
    run_load(100, lat);
    n_tests++;
    if ({load_error_a, load_done_a, core_reset_a} !== 3'b101) begin
      n_fail++;
      $display("FAIL csum_bad got e=%b d=%b cr=%b exp 1 0 1", load_error_a, load_done_a, core_reset_a);
    end
    frame_q[frame_q.size()-1] = 8'hF6;
    run_load(100, lat);
    n_tests++;
    if ({load_error_a, load_done_a, core_reset_a} !== 3'b010 || wr_a.size() != 1) begin
      n_fail++;
      $display("FAIL csum_good got e=%b d=%b cr=%b writes=%0d exp 0 1 0 1",
               load_error_a, load_done_a, core_reset_a, wr_a.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    words_q = '{$urandom, $urandom, $urandom};
    build_frame();
    model_writes();
    pulse_start();
    drive_bytes(2 + 6, 100);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rx_ready_a, imem_we_a, pc_a, instr_a, core_reset_a, load_done_a, load_error_a} !==
        {1'b0, 1'b0, PC_A, 32'h0, 1'b1, 1'b0, 1'b0} || pc_b !== PC_B || core_reset_b !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs got rdy=%b we=%b pc=%0d in=%h cr=%b d=%b e=%b pc_b=%0d",
               rx_ready_a, imem_we_a, pc_a, instr_a, core_reset_a, load_done_a, load_error_a, pc_b);
    end
    @(negedge clock);
    reset = 1'b1;
    run_load(100, lat);
    n_tests++;
    if (wr_a.size() != 3 || wr_a[0] !== exp_a[0] || wr_a[2] !== exp_a[2] || wr_b[1] !== exp_b[1] ||
        load_done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload got n=%0d w0=%h w2=%h b1=%h done=%b exp 3 %h %h %h 1",
               wr_a.size(), wr_a[0], wr_a[2], wr_b[1], load_done_a, exp_a[0], exp_a[2], exp_b[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
